// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: req/ack data-memory access, lane steering, load extension.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses without touching memory.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state, state_nx;
  logic [31:0]   a_q, wd_q, ld_q;
  logic [2:0]    lt_q;
  logic [1:0]    st_q;
  logic          store_q, err_q;
  logic [CW-1:0] wcnt;

  logic          is_store_in, is_load_in, start, misalign, expire;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ext, wd_lane;
  logic [3:0]    be_raw;

  // A store wins when the decoder flags both a load and a store.
  assign is_store_in = mem_we && (store_type != 2'd0);
  assign is_load_in  = (load_type >= 3'd1) && (load_type <= 3'd5);
  assign start       = (state == S_IDLE) && mem_valid && (is_store_in || is_load_in);
  assign expire      = (wcnt == WAIT_LAST);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (is_store_in)
      misalign = ((store_type == 2'd2) && addr[0]) ||
                 ((store_type == 2'd3) && (addr[1:0] != 2'b00));
    else
      misalign = (((load_type == 3'd2) || (load_type == 3'd5)) && addr[0]) ||
                 ((load_type == 3'd3) && (addr[1:0] != 2'b00));
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = misalign ? S_DONE : S_REQ;
      S_REQ:   if (dm_ack || expire) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    ext      = 32'h0;
    case (a_q[1:0])
      2'd0:    byte_sel = dm_rdata[7:0];
      2'd1:    byte_sel = dm_rdata[15:8];
      2'd2:    byte_sel = dm_rdata[23:16];
      default: byte_sel = dm_rdata[31:24];
    endcase
    half_sel = a_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (lt_q)
      3'd1:    ext = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    ext = {{16{half_sel[15]}}, half_sel};
      3'd3:    ext = dm_rdata;
      3'd4:    ext = {24'h0, byte_sel};
      3'd5:    ext = {16'h0, half_sel};
      default: ext = 32'h0;
    endcase
  end

  always_comb begin
    be_raw  = 4'b0000;
    wd_lane = 32'h0;
    case (st_q)
      2'd1: begin
        be_raw  = 4'b0001 << a_q[1:0];
        wd_lane = {4{wd_q[7:0]}};
      end
      2'd2: begin
        be_raw  = a_q[1] ? 4'b1100 : 4'b0011;
        wd_lane = {2{wd_q[15:0]}};
      end
      2'd3: begin
        be_raw  = 4'b1111;
        wd_lane = wd_q;
      end
      default: be_raw = (lt_q != 3'd0) ? 4'b1111 : 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= 32'h0;
      wd_q    <= 32'h0;
      lt_q    <= 3'd0;
      st_q    <= 2'd0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 32'h0;
      wcnt    <= '0;
    end else if (start) begin
      a_q     <= addr;
      wd_q    <= wdata;
      store_q <= is_store_in;
      lt_q    <= is_store_in ? 3'd0 : load_type;
      st_q    <= is_store_in ? store_type : 2'd0;
      wcnt    <= '0;
      err_q   <= misalign;
      if (misalign) ld_q <= 32'h0;
    end else if (state == S_REQ) begin
      // An ack landing on the expiry cycle still counts as a good completion.
      if (dm_ack) begin
        err_q <= 1'b0;
        if (!store_q) ld_q <= ext;
      end else if (expire) begin
        err_q <= 1'b1;
        if (!store_q) ld_q <= 32'h0;
      end else begin
        wcnt <= wcnt + CW'(1);
      end
    end
  end

  assign stall    = start || (state == S_REQ);
  assign done     = (state == S_DONE);
  assign err      = done && err_q;
  assign ld_data  = ld_q;
  assign dm_req   = (state == S_REQ);
  assign dm_we    = dm_req && store_q;
  assign dm_addr  = {a_q[31:2], 2'b00};
  assign dm_be    = dm_req ? be_raw : 4'b0000;
  assign dm_wdata = wd_lane;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit (MAX_WAIT=4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_we = 1'b0;
  logic [2:0]  load_type = 3'd0;
  logic [1:0]  store_type = 2'd0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        stall, done, err, dm_req, dm_we;
  logic [31:0] ld_data, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we),
    .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
    .stall(stall), .ld_data(ld_data), .done(done), .err(err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_we;
    logic [31:0] e_ld;
    logic        e_err;
    int          e_cyc;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_valid = 1'b0; mem_we = 1'b0; load_type = 3'd0; store_type = 2'd0;
  endtask

  task automatic drive_start(input logic we, input logic [2:0] lt, input logic [1:0] st,
                             input logic [31:0] a, input logic [31:0] wd);
    mem_valid = 1'b1; mem_we = we; load_type = lt; store_type = st; addr = a; wdata = wd;
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    bit  seen;
    @(negedge clk);
    drive_start(v.we, v.lt, v.st, v.a, v.wd);
    #1 check({v.name, ".start_stall"}, {31'h0, stall}, 32'h1);
    @(negedge clk);
    clear_inputs();
    #1;
    check({v.name, ".req"},   {31'h0, dm_req}, 32'h1);
    check({v.name, ".addr"},  dm_addr, v.e_addr);
    check({v.name, ".be"},    {28'h0, dm_be}, {28'h0, v.e_be});
    check({v.name, ".we"},    {31'h0, dm_we}, {31'h0, v.e_we});
    if (v.e_we) check({v.name, ".wdata"}, dm_wdata, v.e_wd);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      if (n == v.dly) begin dm_ack = 1'b1; dm_rdata = v.rd; end
      else            begin dm_ack = 1'b0; dm_rdata = 32'h5A5A5A5A; end
      @(negedge clk);
      dm_ack = 1'b0;
      n++;
      #1;
      if (done) seen = 1;
      else check({v.name, ".hold"}, {dm_req, stall, dm_be, dm_addr[25:0]},
                 {1'b1, 1'b1, v.e_be, v.e_addr[25:0]});
    end
    check({v.name, ".done_seen"}, {31'h0, seen}, 32'h1);
    check({v.name, ".latency"}, n, v.e_cyc);
    check({v.name, ".err"}, {31'h0, err}, {31'h0, v.e_err});
    check({v.name, ".ld_data"}, ld_data, v.e_ld);
    check({v.name, ".done_release"}, {30'h0, stall, dm_req}, 32'h0);
  endtask

  function automatic vec_t mk(string nm, logic we, logic [2:0] lt, logic [1:0] st,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd, int dly,
                              logic [31:0] ea, logic [3:0] ebe, logic [31:0] ewd, logic ewe,
                              logic [31:0] eld, logic eerr, int ecyc);
    vec_t v;
    v.name = nm; v.we = we; v.lt = lt; v.st = st; v.a = a; v.wd = wd; v.rd = rd; v.dly = dly;
    v.e_addr = ea; v.e_be = ebe; v.e_wd = ewd; v.e_we = ewe; v.e_ld = eld; v.e_err = eerr; v.e_cyc = ecyc;
    return v;
  endfunction

  initial begin
    vq.push_back(mk("lw_100",  0, 3'd3, 2'd0, 32'h100, 0, 32'hDEADBEEF, 0,   32'h100, 4'hF, 0, 0, 32'hDEADBEEF, 0, 1));
    vq.push_back(mk("lb_103",  0, 3'd1, 2'd0, 32'h103, 0, 32'h80112233, 0,   32'h100, 4'hF, 0, 0, 32'hFFFFFF80, 0, 1));
    vq.push_back(mk("lbu_103", 0, 3'd4, 2'd0, 32'h103, 0, 32'h80112233, 0,   32'h100, 4'hF, 0, 0, 32'h00000080, 0, 1));
    vq.push_back(mk("lhu_102", 0, 3'd5, 2'd0, 32'h102, 0, 32'h80112233, 0,   32'h100, 4'hF, 0, 0, 32'h00008011, 0, 1));
    vq.push_back(mk("lh_102",  0, 3'd2, 2'd0, 32'h102, 0, 32'h80112233, 2,   32'h100, 4'hF, 0, 0, 32'hFFFF8011, 0, 3));
    vq.push_back(mk("lb_101",  0, 3'd1, 2'd0, 32'h101, 0, 32'h80112233, 0,   32'h100, 4'hF, 0, 0, 32'h00000022, 0, 1));
    vq.push_back(mk("sh_206",  1, 3'd0, 2'd2, 32'h206, 32'h1234ABCD, 32'hFFFFFFFF, 0, 32'h204, 4'hC, 32'hABCDABCD, 1, 32'h00000022, 0, 1));
    vq.push_back(mk("sb_201",  1, 3'd0, 2'd1, 32'h201, 32'h1234ABCD, 32'hFFFFFFFF, 1, 32'h200, 4'h2, 32'hCDCDCDCD, 1, 32'h00000022, 0, 2));
    vq.push_back(mk("sw_ack_at_expiry", 1, 3'd0, 2'd3, 32'h300, 32'hCAFEF00D, 0, 3, 32'h300, 4'hF, 32'hCAFEF00D, 1, 32'h00000022, 0, 4));
    vq.push_back(mk("lw_watchdog", 0, 3'd3, 2'd0, 32'h400, 0, 0, 255, 32'h400, 4'hF, 0, 0, 32'h0, 1, 4));
    vq.push_back(mk("ld_st_both_store_wins", 1, 3'd3, 2'd3, 32'h500, 32'h01020304, 32'h77777777, 0, 32'h500, 4'hF, 32'h01020304, 1, 32'h0, 0, 1));
`ifndef MISALIGN_TRAP_EN
    vq.push_back(mk("sw_102_noalign", 1, 3'd0, 2'd3, 32'h102, 32'h11223344, 0, 0, 32'h100, 4'hF, 32'h11223344, 1, 32'h0, 0, 1));
    vq.push_back(mk("lhu_101_noalign", 0, 3'd5, 2'd0, 32'h101, 0, 32'h80112233, 0, 32'h100, 4'hF, 0, 0, 32'h00002233, 0, 1));
`endif

    // reset state
    @(negedge clk);
    #1;
    check("reset.outs", {stall, done, err, dm_req, dm_we, dm_be}, 9'h0);
    check("reset.ld_data", ld_data, 32'h0);
    check("reset.dm_addr", dm_addr, 32'h0);
    check("reset.dm_wdata", dm_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) run_vec(vq[i]);

    // dm_ack while idle must not complete anything
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    check("idle_ack.done", {31'h0, done}, 32'h0);
    check("idle_ack.ld_data", ld_data, vq[vq.size()-1].e_ld);

    // DONE ignores a new request; IDLE re-evaluates next cycle
    @(negedge clk);
    drive_start(0, 3'd3, 2'd0, 32'h700, 0);
    @(negedge clk);
    clear_inputs();
    dm_ack = 1'b1; dm_rdata = 32'h12345678;
    @(negedge clk);
    dm_ack = 1'b0;
    drive_start(0, 3'd3, 2'd0, 32'h800, 0);
    #1;
    check("done_ignore.done", {31'h0, done}, 32'h1);
    check("done_ignore.stall", {31'h0, stall}, 32'h0);
    check("done_ignore.ld", ld_data, 32'h12345678);
    @(negedge clk);
    clear_inputs();
    #1;
    check("done_ignore.no_reissue", {31'h0, dm_req}, 32'h0);
    @(negedge clk);
    #1;
    check("done_ignore.idle", {dm_req, done}, 2'b00);

    // reset in the 3rd wait cycle of an outstanding load
    @(negedge clk);
    drive_start(0, 3'd3, 2'd0, 32'h600, 0);
    @(negedge clk);
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 check("rst_mid.stall_held", {30'h0, stall, dm_req}, 32'h3);
    end
    rst = 1'b1;
    #1;
    check("rst_mid.req_drop", {30'h0, stall, dm_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid.idle", {done, err, dm_req}, 3'b000);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    drive_start(1, 3'd0, 2'd3, 32'h102, 32'h11223344);
    #1 check("trap.start_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    clear_inputs();
    #1;
    check("trap.done_err", {30'h0, done, err}, 32'h3);
    check("trap.no_req", {30'h0, dm_req, stall}, 32'h0);
    check("trap.ld_data", ld_data, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
